core_net_ingress: RTL and testbench

//  Receiving end of the host->core network protocol. Decodes net packets addressed to this core into

---
 rtl/core_net_ingress_pkg.sv | 36 +++
 rtl/core_net_ingress_if.sv | 37 +++
 rtl/core_net_ingress_net_reg_fifo.sv | 47 ++++
 rtl/core_net_ingress.sv | 148 ++++++++++++++
 tb/tb_core_net_ingress.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_net_ingress_pkg.sv
// Shared types for the host->core network ingress: packet layout, opcodes, run states.
// No logic; latency and backpressure are properties of the modules that import this.
// The register-write queue is the only buffered path.
package core_net_ingress_pkg;

    localparam int mask_length_gp = 3;

    typedef enum logic [2:0] {
        NULL  = 3'd0,
        INSTR = 3'd1,
        REG   = 3'd2,
        PC    = 3'd3,
        BAR   = 3'd4
    } net_op_e;

    typedef struct packed {
        logic [9:0]  ID;
        net_op_e     net_op;
        logic [4:0]  reserved;
        logic [31:0] net_data;
        logic [9:0]  net_addr;
    } net_packet_s;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs;
    } instruction_s;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        DRAIN = 2'd1,
        RUN   = 2'd2
    } run_state_e;

endpackage

// File: rtl/core_net_ingress_if.sv
// Bundle between the network ingress and the core datapath it loads.
// Pure wiring: no latency, no backpressure of its own.
// master = the ingress block, slave = the core/network side.
interface core_net_ingress_if import core_net_ingress_pkg::*; #(
    parameter int imem_addr_width_p = 10,
    parameter int rf_addr_width_p   = 6,
    parameter int mask_length_p     = mask_length_gp
);
    net_packet_s                  net_packet_i;
    logic                         core_rf_wen_i;
    logic                         core_halt_i;
    logic                         imem_wen_o;
    logic [imem_addr_width_p-1:0] imem_addr_o;
    instruction_s                 imem_data_o;
    logic                         rf_wen_o;
    logic [rf_addr_width_p-1:0]   rf_addr_o;
    logic [31:0]                  rf_data_o;
    logic                         pc_wen_o;
    logic [imem_addr_width_p-1:0] pc_o;
    logic                         run_o;
    logic [mask_length_p-1:0]     barrier_mask_o;
    logic [mask_length_p-1:0]     barrier_o;
    logic                         overflow_o;

    modport master (
        input  net_packet_i, core_rf_wen_i, core_halt_i,
        output imem_wen_o, imem_addr_o, imem_data_o, rf_wen_o, rf_addr_o, rf_data_o,
        output pc_wen_o, pc_o, run_o, barrier_mask_o, barrier_o, overflow_o
    );

    modport slave (
        output net_packet_i, core_rf_wen_i, core_halt_i,
        input  imem_wen_o, imem_addr_o, imem_data_o, rf_wen_o, rf_addr_o, rf_data_o,
        input  pc_wen_o, pc_o, run_o, barrier_mask_o, barrier_o, overflow_o
    );

endinterface

// File: rtl/core_net_ingress_net_reg_fifo.sv
// Generic synchronous FIFO with head-of-queue visibility.
// Entry pushed at an edge is visible at head_data in the following cycle.
// Push while full is ignored unless a pop happens in the same cycle.
module net_reg_fifo #(
    parameter int width_p = 38,
    parameter int depth_p = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [width_p-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [width_p-1:0] head_data
);
    localparam int ptr_w = $clog2(depth_p);

    logic [width_p-1:0] mem [depth_p];
    logic [ptr_w:0]     wr_ptr;
    logic [ptr_w:0]     rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[ptr_w] != rd_ptr[ptr_w]) &&
                       (wr_ptr[ptr_w-1:0] == rd_ptr[ptr_w-1:0]);
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign head_data = mem[rd_ptr[ptr_w-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[ptr_w-1:0]] <= push_data;
    end

endmodule

// File: rtl/core_net_ingress.sv
// Decodes host->core packets into imem/RF/PC/barrier writes and owns core run/halt.
// Packet registered at edge t, its effect appears after edge t+1; RF writes queue behind core writeback.
// Core writeback stalls the RF queue; a REG packet arriving at a full, non-draining queue is dropped.
module core_net_ingress import core_net_ingress_pkg::*; #(
    parameter logic [9:0] net_ID_p          = 10'd1,
    parameter int         imem_addr_width_p = 10,
    parameter int         rf_addr_width_p   = 6,
    parameter int         mask_length_p     = mask_length_gp,
    parameter int         fifo_depth_p      = 4
) (
    input  logic              clk,
    input  logic              reset,
    core_net_ingress_if.master bus
);
    typedef struct packed {
        logic [rf_addr_width_p-1:0] addr;
        logic [31:0]                data;
    } rf_entry_s;

    logic [9:0]  id_r;
    net_op_e     op_r;
    logic [31:0] data_r;
    logic [9:0]  addr_r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            id_r   <= '0;
            op_r   <= NULL;
            data_r <= '0;
            addr_r <= '0;
        end else begin
            id_r   <= bus.net_packet_i.ID;
            op_r   <= bus.net_packet_i.net_op;
            data_r <= bus.net_packet_i.net_data;
            addr_r <= bus.net_packet_i.net_addr;
        end
    end

    logic pkt_vld, instr_vld, reg_vld, pc_vld, bar_vld;
    assign pkt_vld   = (id_r == net_ID_p) && (op_r != NULL);
    assign instr_vld = pkt_vld && (op_r == INSTR);
    assign reg_vld   = pkt_vld && (op_r == REG);
    assign pc_vld    = pkt_vld && (op_r == PC);
    assign bar_vld   = pkt_vld && (op_r == BAR);

    rf_entry_s push_entry, head;
    logic      fifo_full, fifo_empty, rf_wen;

    assign push_entry = '{addr: addr_r[rf_addr_width_p-1:0], data: data_r};

    net_reg_fifo #(
        .width_p (rf_addr_width_p + 32),
        .depth_p (fifo_depth_p)
    ) u_reg_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (reg_vld),
        .push_data (push_entry),
        .pop       (rf_wen),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head)
    );

    // Core writeback owns the RF port; the queue only uses idle cycles.
    assign rf_wen        = !fifo_empty && !bus.core_rf_wen_i;
    assign bus.rf_wen_o  = rf_wen;
    assign bus.rf_addr_o = fifo_empty ? '0 : head.addr;
    assign bus.rf_data_o = fifo_empty ? '0 : head.data;

    logic                         imem_wen_q, overflow_q;
    logic [imem_addr_width_p-1:0] imem_addr_q;
    instruction_s                 imem_data_q;
    logic [mask_length_p-1:0]     mask_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            imem_wen_q  <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            mask_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            imem_wen_q <= instr_vld;
            if (instr_vld) begin
                imem_addr_q <= addr_r[imem_addr_width_p-1:0];
                imem_data_q <= instruction_s'(data_r[15:0]);
            end
            if (bar_vld) mask_q <= data_r[mask_length_p-1:0];
            if (reg_vld && fifo_full && !rf_wen) overflow_q <= 1'b1;
        end
    end

    run_state_e                   state;
    logic [imem_addr_width_p-1:0] pc_q;
    logic [mask_length_p-1:0]     barrier_q;
    logic                         pc_wen_q, run_q;

    // pc_wen_o fires on entry to RUN; run_o follows one cycle later so the PC is loaded first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= HALT;
            pc_q      <= '0;
            barrier_q <= '0;
            pc_wen_q  <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            pc_wen_q <= 1'b0;
            if (pc_vld) begin
                pc_q      <= addr_r[imem_addr_width_p-1:0];
                barrier_q <= data_r[mask_length_p-1:0];
                run_q     <= 1'b0;
                state     <= DRAIN;
            end else begin
                case (state)
                    HALT: run_q <= 1'b0;
                    DRAIN: begin
                        if (fifo_empty && !reg_vld) begin
                            pc_wen_q <= 1'b1;
                            state    <= RUN;
                        end
                    end
                    RUN: begin
                        if (bus.core_halt_i) begin
                            run_q     <= 1'b0;
                            barrier_q <= '0;
                            state     <= HALT;
                        end else begin
                            run_q <= 1'b1;
                        end
                    end
                    default: state <= HALT;
                endcase
            end
        end
    end

    assign bus.imem_wen_o     = imem_wen_q;
    assign bus.imem_addr_o    = imem_addr_q;
    assign bus.imem_data_o    = imem_data_q;
    assign bus.barrier_mask_o = mask_q;
    assign bus.overflow_o     = overflow_q;
    assign bus.pc_wen_o       = pc_wen_q;
    assign bus.pc_o           = pc_q;
    assign bus.run_o          = run_q;
    assign bus.barrier_o      = barrier_q;

endmodule

// File: tb/tb_core_net_ingress.sv
// Directed + randomized bench for core_net_ingress against a queue-based reference model.
module tb_core_net_ingress;
    import core_net_ingress_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    core_net_ingress_if bus ();
    core_net_ingress dut (.clk(clk), .reset(reset), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    typedef struct { logic [5:0] a; logic [31:0] d; } rf_t;
    rf_t         mq[$];
    net_packet_s stage_p = '0, act_p = '0;
    logic        m_ovf = 0, m_imem_wen = 0;
    logic [9:0]  m_imem_addr = 0, m_pc = 0;
    logic [15:0] m_imem_data = 0;
    logic [2:0]  m_mask = 0, m_bar = 0;
    bit          m_drain = 0, m_pcw = 0, m_run = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_op(input net_packet_s p, input net_op_e op);
        return (p.ID == 10'd1) && (p.net_op == op);
    endfunction

    // Reference model: advances one clock edge using the inputs the DUT just sampled.
    task automatic model_edge();
        bit pop, full, was_empty, is_reg;
        if (!reset) begin
            mq.delete();
            stage_p = '0; act_p = '0;
            m_ovf = 0; m_imem_wen = 0; m_imem_addr = 0; m_imem_data = 0;
            m_mask = 0; m_bar = 0; m_pc = 0; m_drain = 0; m_pcw = 0; m_run = 0;
            return;
        end
        act_p     = stage_p;
        stage_p   = bus.net_packet_i;
        was_empty = (mq.size() == 0);
        full      = (mq.size() == 4);
        pop       = !was_empty && !bus.core_rf_wen_i;
        is_reg    = is_op(act_p, REG);
        if (pop) void'(mq.pop_front());
        if (is_reg) begin
            if (full && !pop) m_ovf = 1;
            else mq.push_back('{act_p.net_addr[5:0], act_p.net_data});
        end
        m_imem_wen = is_op(act_p, INSTR);
        if (m_imem_wen) begin
            m_imem_addr = act_p.net_addr;
            m_imem_data = act_p.net_data[15:0];
        end
        if (is_op(act_p, BAR)) m_mask = act_p.net_data[2:0];
        if (is_op(act_p, PC)) begin
            m_pc = act_p.net_addr; m_bar = act_p.net_data[2:0];
            m_drain = 1; m_pcw = 0; m_run = 0;
        end else if (m_drain) begin
            if (was_empty && !is_reg) begin m_pcw = 1; m_drain = 0; end
        end else if (m_pcw) begin
            m_pcw = 0;
            if (bus.core_halt_i) m_bar = 0; else m_run = 1;
        end else if (m_run && bus.core_halt_i) begin
            m_run = 0; m_bar = 0;
        end
    endtask

    task automatic check_all();
        chk("imem_wen", 32'(bus.imem_wen_o), 32'(m_imem_wen));
        chk("imem_addr", 32'(bus.imem_addr_o), 32'(m_imem_addr));
        chk("imem_data", 32'(bus.imem_data_o), 32'(m_imem_data));
        chk("rf_wen", 32'(bus.rf_wen_o), 32'(mq.size() > 0 && !bus.core_rf_wen_i));
        if (mq.size() > 0) begin
            chk("rf_addr", 32'(bus.rf_addr_o), 32'(mq[0].a));
            chk("rf_data", bus.rf_data_o, mq[0].d);
        end
        chk("pc_wen", 32'(bus.pc_wen_o), 32'(m_pcw));
        chk("pc", 32'(bus.pc_o), 32'(m_pc));
        chk("run", 32'(bus.run_o), 32'(m_run));
        chk("barrier", 32'(bus.barrier_o), 32'(m_bar));
        chk("barrier_mask", 32'(bus.barrier_mask_o), 32'(m_mask));
        chk("overflow", 32'(bus.overflow_o), 32'(m_ovf));
    endtask

    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(input net_op_e op, input logic [9:0] id, input logic [9:0] addr,
                        input logic [31:0] data);
        bus.net_packet_i = '{ID: id, net_op: op, reserved: 5'd0, net_data: data, net_addr: addr};
        step();
        bus.net_packet_i = '0;
    endtask

    task automatic wait_pc_wen(input string tag);
        bit seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.pc_wen_o) begin seen = 1; break; end
            step();
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        rf_t exp5[5];
        bit  seen;
        net_op_e op;

        bus.net_packet_i = '0;
        bus.core_rf_wen_i = 0;
        bus.core_halt_i = 0;
        @(posedge clk);
        model_edge();
        #1;
        step(); step();
        chk("rst_imem_wen", 32'(bus.imem_wen_o), 0);
        chk("rst_rf_wen", 32'(bus.rf_wen_o), 0);
        chk("rst_run", 32'(bus.run_o), 0);
        chk("rst_overflow", 32'(bus.overflow_o), 0);
        reset = 1;

        // INSTR to this core, then to another ID
        send(INSTR, 10'd1, 10'd5, 32'h0000_1234);
        step();
        chk("instr_wen", 32'(bus.imem_wen_o), 1);
        chk("instr_addr", 32'(bus.imem_addr_o), 5);
        chk("instr_data", 32'(bus.imem_data_o), 32'h1234);
        step();
        send(INSTR, 10'd2, 10'd9, 32'h0000_5678);
        step();
        chk("foreign_id_wen", 32'(bus.imem_wen_o), 0);
        step();

        // REG held off by core writeback
        bus.core_rf_wen_i = 1;
        send(REG, 10'd1, 10'd3, 32'hCAFE_BABE);
        step(); step(); step();
        chk("reg_stalled", 32'(bus.rf_wen_o), 0);
        bus.core_rf_wen_i = 0;
        #1;
        chk("reg_wen", 32'(bus.rf_wen_o), 1);
        chk("reg_addr", 32'(bus.rf_addr_o), 3);
        chk("reg_data", bus.rf_data_o, 32'hCAFE_BABE);
        step();
        chk("reg_empty", 32'(bus.rf_wen_o), 0);

        // Five REGs into a four-deep stalled queue
        bus.core_rf_wen_i = 1;
        for (int i = 0; i < 5; i++) begin
            exp5[i].a = 6'($urandom_range(0, 63));
            exp5[i].d = $urandom;
            send(REG, 10'd1, 10'(exp5[i].a), exp5[i].d);
        end
        step(); step();
        chk("ovf_set", 32'(bus.overflow_o), 1);
        bus.core_rf_wen_i = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_wen", 32'(bus.rf_wen_o), 1);
            chk("drain_addr", 32'(bus.rf_addr_o), 32'(exp5[i].a));
            chk("drain_data", bus.rf_data_o, exp5[i].d);
            step();
        end
        chk("drain_done", 32'(bus.rf_wen_o), 0);
        chk("ovf_sticky", 32'(bus.overflow_o), 1);

        // PC waits for queued RF writes
        send(REG, 10'd1, 10'd7, $urandom);
        send(REG, 10'd1, 10'd8, $urandom);
        send(PC, 10'd1, 10'd0, 32'd2);
        wait_pc_wen("pc_wen_seen");
        chk("pc_after_rf", 32'(bus.rf_wen_o), 0);
        chk("pc_val", 32'(bus.pc_o), 0);
        chk("pc_barrier", 32'(bus.barrier_o), 3'b010);
        step();
        chk("run_on", 32'(bus.run_o), 1);

        // Halt pulse in RUN, then halt coinciding with a PC packet
        bus.core_halt_i = 1;
        step();
        bus.core_halt_i = 0;
        chk("halt_run", 32'(bus.run_o), 0);
        chk("halt_barrier", 32'(bus.barrier_o), 0);
        send(PC, 10'd1, 10'h2A, 32'd4);
        wait_pc_wen("pc_wen_restart");
        step(); step();
        chk("run_again", 32'(bus.run_o), 1);
        send(PC, 10'd1, 10'h15, 32'd1);
        bus.core_halt_i = 1;
        step();
        bus.core_halt_i = 0;
        chk("pcwin_run", 32'(bus.run_o), 0);
        chk("pcwin_barrier", 32'(bus.barrier_o), 3'b001);
        chk("pcwin_pc", 32'(bus.pc_o), 10'h15);
        wait_pc_wen("pc_wen_pcwin");
        step(); step();

        // Barrier mask, then reset while draining
        send(BAR, 10'd1, 10'd0, 32'd7);
        step();
        chk("bar_mask", 32'(bus.barrier_mask_o), 3'b111);
        bus.core_rf_wen_i = 1;
        send(REG, 10'd1, 10'd9, $urandom);
        send(PC, 10'd1, 10'h33, 32'd5);
        step(); step(); step();
        chk("drain_hold_pcw", 32'(bus.pc_wen_o), 0);
        chk("drain_hold_run", 32'(bus.run_o), 0);
        reset = 0;
        step(); step();
        chk("rst2_mask", 32'(bus.barrier_mask_o), 0);
        chk("rst2_barrier", 32'(bus.barrier_o), 0);
        chk("rst2_pc", 32'(bus.pc_o), 0);
        chk("rst2_ovf", 32'(bus.overflow_o), 0);
        chk("rst2_rf_wen", 32'(bus.rf_wen_o), 0);
        reset = 1;
        bus.core_rf_wen_i = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.pc_wen_o) seen = 1;
            step();
        end
        chk("no_pc_after_rst", 32'(seen), 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            op = net_op_e'($urandom_range(0, 4));
            if (op == PC && $urandom_range(0, 3) != 0) op = REG;
            bus.net_packet_i = '{ID: ($urandom_range(0, 7) == 0) ? 10'd2 : 10'd1, net_op: op,
                                 reserved: 5'($urandom), net_data: $urandom,
                                 net_addr: 10'($urandom)};
            bus.core_rf_wen_i = ($urandom_range(0, 2) == 0);
            bus.core_halt_i = m_run && ($urandom_range(0, 7) == 0);
            step();
        end
        bus.net_packet_i = '0;
        bus.core_rf_wen_i = 0;
        bus.core_halt_i = 0;
        for (int i = 0; i < 12; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
